// File: rtl/prefetch_fill_ctrl_if.sv
// Fill controller bundle: request side, buffer handshake/write port, memory burst-read port.
// master = fill controller, slave = the surrounding request source, buffer and memory.
interface prefetch_fill_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_start_address;
  logic [31:0] req_length;
  logic        buf_idle;
  logic        buf_wait_prefetch_en;
  logic        buf_prefetch_en;
  logic        buf_prefetch_finish;
  logic [31:0] buf_start_address;
  logic [31:0] buf_length;
  logic        buf_write;
  logic [63:0] buf_data_in;
  logic [31:0] buf_data_in_address;
  logic        mem_rd_req_valid;
  logic        mem_rd_req_ready;
  logic [31:0] mem_rd_addr;
  logic [7:0]  mem_rd_len;
  logic        mem_rd_data_valid;
  logic [63:0] mem_rd_data;
  logic        busy;
  logic        len_overflow;

  modport master (
    input  req_valid, req_start_address, req_length, buf_idle,
           mem_rd_req_ready, mem_rd_data_valid, mem_rd_data,
    output req_ready, buf_wait_prefetch_en, buf_prefetch_en, buf_prefetch_finish,
           buf_start_address, buf_length, buf_write, buf_data_in, buf_data_in_address,
           mem_rd_req_valid, mem_rd_addr, mem_rd_len, busy, len_overflow
  );

  modport slave (
    output req_valid, req_start_address, req_length, buf_idle,
           mem_rd_req_ready, mem_rd_data_valid, mem_rd_data,
    input  req_ready, buf_wait_prefetch_en, buf_prefetch_en, buf_prefetch_finish,
           buf_start_address, buf_length, buf_write, buf_data_in, buf_data_in_address,
           mem_rd_req_valid, mem_rd_addr, mem_rd_len, busy, len_overflow
  );
endinterface

// File: rtl/prefetch_fill_ctrl.sv
// Prefetch buffer fill sequencer: burst-reads the words covering a byte range and writes them by index.
// Data beats pass straight through to the buffer write port; burst requests hold until mem_rd_req_ready.
// Optional PREFETCH_FILL_STATS_EN adds stat_fill_cycles_o (ARM..DONE cycle count, saturating).
module prefetch_fill_ctrl #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned MAX_BURST   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  prefetch_fill_ctrl_if.master ctrl_io
`ifdef PREFETCH_FILL_STATS_EN
  ,
  output logic [31:0]          stat_fill_cycles_o
`endif
);

  localparam int unsigned   AW          = $clog2(DEPTH_WORDS);
  localparam int unsigned   CW          = AW + 1;
  localparam logic [32:0]   DEPTH_33    = 33'(DEPTH_WORDS);
  localparam logic [CW-1:0] DEPTH_CW    = CW'(DEPTH_WORDS);
  localparam logic [31:0]   DEPTH_BYTES = 32'(DEPTH_WORDS * 8);
  localparam logic [31:0]   MAX_32      = 32'(MAX_BURST);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_FILL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q,  state_d;
  logic [31:0]   base_q,   base_d;
  logic [31:0]   start_q,  start_d;
  logic [31:0]   blen_q,   blen_d;
  logic [CW-1:0] beats_q,  beats_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] recv_q,   recv_d;
  logic          ovf_q,    ovf_d;

  logic          accept;
  logic          req_vld;
  logic          req_fire;
  logic          beat_fire;
  logic [32:0]   beats_raw;
  logic [CW-1:0] remain;
  logic [7:0]    burst_len;

  assign accept    = !rst_i && (state_q == S_IDLE) && ctrl_io.buf_idle && ctrl_io.req_valid;
  // 33-bit sum so a length near 4 GiB cannot wrap the beat count
  assign beats_raw = ({30'd0, ctrl_io.req_start_address[2:0]} + {1'b0, ctrl_io.req_length} + 33'd7) >> 3;
  assign remain    = beats_q - issued_q;
  assign burst_len = (32'(remain) > MAX_32) ? MAX_32[7:0] : 8'(remain);
  assign req_vld   = !rst_i && (state_q == S_FILL) && (issued_q != beats_q);
  assign req_fire  = req_vld && ctrl_io.mem_rd_req_ready;
  assign beat_fire = !rst_i && (state_q == S_FILL) && ctrl_io.mem_rd_data_valid && (recv_q != beats_q);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    start_d  = start_q;
    blen_d   = blen_q;
    beats_d  = beats_q;
    issued_d = issued_q;
    recv_d   = recv_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_ARM;
          base_d   = {ctrl_io.req_start_address[31:3], 3'b000};
          start_d  = ctrl_io.req_start_address;
          issued_d = '0;
          recv_d   = '0;
          if (beats_raw > DEPTH_33) begin
            beats_d = DEPTH_CW;
            blen_d  = DEPTH_BYTES - {29'd0, ctrl_io.req_start_address[2:0]};
            ovf_d   = 1'b1;
          end else begin
            beats_d = beats_raw[CW-1:0];
            blen_d  = ctrl_io.req_length;
            ovf_d   = 1'b0;
          end
        end
      end
      S_ARM:   state_d = S_START;
      S_START: state_d = (beats_q == '0) ? S_DONE : S_FILL;
      S_FILL: begin
        if (req_fire) begin
          issued_d = issued_q + CW'(burst_len);
        end
        if (beat_fire) begin
          recv_d = recv_q + CW'(1);
        end
        // leaving on the last beat puts the finish pulse exactly one cycle after the last write
        if (recv_d == beats_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      start_q  <= '0;
      blen_q   <= '0;
      beats_q  <= '0;
      issued_q <= '0;
      recv_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      start_q  <= start_d;
      blen_q   <= blen_d;
      beats_q  <= beats_d;
      issued_q <= issued_d;
      recv_q   <= recv_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ctrl_io.req_ready            = !rst_i && (state_q == S_IDLE) && ctrl_io.buf_idle;
  assign ctrl_io.buf_wait_prefetch_en = (state_q == S_ARM);
  assign ctrl_io.buf_prefetch_en      = (state_q == S_START);
  assign ctrl_io.buf_prefetch_finish  = (state_q == S_DONE);
  assign ctrl_io.buf_start_address    = start_q;
  assign ctrl_io.buf_length           = blen_q;
  assign ctrl_io.buf_write            = beat_fire;
  assign ctrl_io.buf_data_in          = beat_fire ? ctrl_io.mem_rd_data : '0;
  assign ctrl_io.buf_data_in_address  = beat_fire ? 32'(recv_q[AW-1:0]) : '0;
  assign ctrl_io.mem_rd_req_valid     = req_vld;
  assign ctrl_io.mem_rd_addr          = req_vld ? (base_q + (32'(issued_q) << 3)) : '0;
  assign ctrl_io.mem_rd_len           = req_vld ? burst_len : '0;
  assign ctrl_io.busy                 = (state_q != S_IDLE);
  assign ctrl_io.len_overflow         = ovf_q;

`ifdef PREFETCH_FILL_STATS_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] stat_q, stat_d;

  always_comb begin
    cyc_d  = cyc_q;
    stat_d = stat_q;
    if (accept) begin
      cyc_d = '0;
    end else if ((state_q == S_ARM) || (state_q == S_START) || (state_q == S_FILL)) begin
      cyc_d = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
    end
    // the DONE cycle itself is counted in the latched value
    if (state_q == S_DONE) begin
      stat_d = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q  <= '0;
      stat_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      stat_q <= stat_d;
    end
  end

  assign stat_fill_cycles_o = stat_q;
`endif

endmodule

// File: tb/tb_prefetch_fill_ctrl.sv
// Directed bench for prefetch_fill_ctrl with a 1-cycle-latency burst memory model and a write/burst scoreboard.
module tb_prefetch_fill_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prefetch_fill_ctrl_if bus();
`ifdef PREFETCH_FILL_STATS_EN
  logic [31:0] stat_fill_cycles;
`endif

  prefetch_fill_ctrl #(.DEPTH_WORDS(4096), .MAX_BURST(16)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .ctrl_io (bus)
`ifdef PREFETCH_FILL_STATS_EN
    ,
    .stat_fill_cycles_o (stat_fill_cycles)
`endif
  );

  typedef struct { logic [31:0] idx; logic [63:0] dat; } wr_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } br_t;
  wr_t         exp_wr[$];
  br_t         exp_br[$];
  logic [31:0] pend[$];

  int chk_cnt = 0, pass_cnt = 0;
  int cyc = 0, wait_cyc = -1, en_cyc = -1, fin_cyc = -1, last_wr_cyc = -1, fin_cnt = 0;
  int wr_cnt = 0, req_cnt = 0, extra_wr = 0, extra_br = 0, drop_wr = 0, stall_seen = 0;
  int burst_no = 0, stall_on = -1, stall_left = 0;
  bit dropping = 1'b0;
  logic [31:0] last_wr_idx = '0;

  function automatic logic [63:0] beat_dat(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt = chk_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // memory model: beats of a burst accepted in cycle N start returning in cycle N+1
  initial begin
    bus.mem_rd_req_ready  = 1'b1;
    bus.mem_rd_data_valid = 1'b0;
    bus.mem_rd_data       = '0;
    forever begin
      @(negedge clk);
      if (pend.size() > 0) begin
        bus.mem_rd_data_valid = 1'b1;
        bus.mem_rd_data       = beat_dat(pend.pop_front());
      end else begin
        bus.mem_rd_data_valid = 1'b0;
        bus.mem_rd_data       = '0;
      end
      if (burst_no == stall_on && stall_left > 0) begin
        bus.mem_rd_req_ready = 1'b0;
        stall_left = stall_left - 1;
      end else begin
        bus.mem_rd_req_ready = 1'b1;
      end
    end
  end

  // sampler: observes settled outputs 2 time units after the inputs change
  initial forever begin
    @(negedge clk);
    #2;
    cyc = cyc + 1;
    if (bus.buf_wait_prefetch_en) wait_cyc = cyc;
    if (bus.buf_prefetch_en) en_cyc = cyc;
    if (bus.buf_prefetch_finish) begin
      fin_cyc = cyc;
      fin_cnt = fin_cnt + 1;
    end
    if (bus.mem_rd_req_valid) begin
      if (!bus.mem_rd_req_ready) stall_seen = stall_seen + 1;
      if (exp_br.size() == 0) extra_br = extra_br + 1;
      else begin
        check("burst_addr", 64'(bus.mem_rd_addr), 64'(exp_br[0].addr));
        check("burst_len", 64'(bus.mem_rd_len), 64'(exp_br[0].len));
        if (bus.mem_rd_req_ready) void'(exp_br.pop_front());
      end
      if (bus.mem_rd_req_ready) begin
        for (int i = 0; i < int'(bus.mem_rd_len); i++) pend.push_back(bus.mem_rd_addr + 32'(i) * 32'd8);
        req_cnt  = req_cnt + 1;
        burst_no = burst_no + 1;
      end
    end
    if (bus.buf_write) begin
      last_wr_cyc = cyc;
      last_wr_idx = bus.buf_data_in_address;
      wr_cnt = wr_cnt + 1;
      if (dropping) drop_wr = drop_wr + 1;
      else if (exp_wr.size() == 0) extra_wr = extra_wr + 1;
      else begin
        check("wr_idx", 64'(bus.buf_data_in_address), 64'(exp_wr[0].idx));
        check("wr_data", bus.buf_data_in, exp_wr[0].dat);
        void'(exp_wr.pop_front());
      end
    end
  end

  task automatic model(input logic [31:0] start, input logic [31:0] len,
                       output int b, output bit ovf, output logic [31:0] blen, output int nb);
    longint lb;
    logic [31:0] base;
    int l;
    lb   = (longint'(start & 32'h7) + longint'(len) + 64'd7) >> 3;
    base = start & ~32'h7;
    ovf  = (lb > 4096);
    if (ovf) begin
      lb   = 4096;
      blen = 32'd32768 - (start & 32'h7);
    end else begin
      blen = len;
    end
    b = int'(lb);
    for (int i = 0; i < b; i++) exp_wr.push_back('{32'(i), beat_dat(base + 32'(i) * 32'd8)});
    nb = 0;
    for (int iss = 0; iss < b; iss += l) begin
      l = (b - iss > 16) ? 16 : b - iss;
      exp_br.push_back('{base + 32'(iss) * 32'd8, 8'(l)});
      nb = nb + 1;
    end
  endtask

  task automatic issue_req(input logic [31:0] start, input logic [31:0] len);
    bit got = 0;
    wr_cnt = 0; req_cnt = 0; burst_no = 0; extra_wr = 0; extra_br = 0; stall_seen = 0;
    wait_cyc = -1; en_cyc = -1; fin_cyc = -1; last_wr_cyc = -1; last_wr_idx = '0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_start_address = start;
    bus.req_length = len;
    for (int t = 0; t < 20; t++) begin
      #3;
      if (bus.req_ready) begin got = 1; break; end
      @(negedge clk);
    end
    check("accept", 64'(got), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #3;
    check("rdy_while_busy", 64'(bus.req_ready), 64'd0);
  endtask

  task automatic run_fill(input logic [31:0] start, input logic [31:0] len);
    int b, nb, fin0;
    bit ovf, got;
    logic [31:0] blen;
    model(start, len, b, ovf, blen, nb);
    fin0 = fin_cnt;
    issue_req(start, len);
    got = 0;
    for (int t = 0; t < b + 300; t++) begin
      if (fin_cnt != fin0) begin got = 1; break; end
      @(negedge clk);
      #3;
    end
    check("finish_seen", 64'(got), 64'd1);
    check("wr_count", 64'(wr_cnt), 64'(b));
    check("burst_count", 64'(req_cnt), 64'(nb));
    check("wr_left", 64'(exp_wr.size()), 64'd0);
    check("extra_wr", 64'(extra_wr), 64'd0);
    check("extra_burst", 64'(extra_br), 64'd0);
    check("en_after_wait", 64'(en_cyc), 64'(wait_cyc + 1));
    if (b > 0) begin
      check("fin_after_last_wr", 64'(fin_cyc), 64'(last_wr_cyc + 1));
      check("last_wr_idx", 64'(last_wr_idx), 64'(b - 1));
    end else begin
      check("fin_after_en", 64'(fin_cyc), 64'(en_cyc + 1));
    end
    check("len_overflow", 64'(bus.len_overflow), 64'(ovf));
    check("buf_length", 64'(bus.buf_length), 64'(blen));
    check("buf_start", 64'(bus.buf_start_address), 64'(start));
    @(negedge clk);
    #3;
    check("idle_after", 64'(bus.busy), 64'd0);
    exp_br.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_ready"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_pulses"}, 64'({bus.buf_wait_prefetch_en, bus.buf_prefetch_en, bus.buf_prefetch_finish}), 64'd0);
    check({tag, "_memreq"}, 64'({bus.mem_rd_req_valid, bus.mem_rd_addr, bus.mem_rd_len}), 64'd0);
    check({tag, "_write"}, 64'({bus.buf_write, bus.buf_data_in_address}), 64'd0);
    check({tag, "_wdata"}, bus.buf_data_in, 64'd0);
    check({tag, "_bufregs"}, {bus.buf_start_address, bus.buf_length}, 64'd0);
    check({tag, "_ovf"}, 64'(bus.len_overflow), 64'd0);
`ifdef PREFETCH_FILL_STATS_EN
    check({tag, "_stat"}, 64'(stat_fill_cycles), 64'd0);
`endif
  endtask

  initial begin
    int b, nb, inflight;
    bit ovf, got;
    logic [31:0] blen;
    bus.req_valid = 1'b0;
    bus.req_start_address = '0;
    bus.req_length = '0;
    bus.buf_idle = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // buffer not idle: request must not be taken
    bus.buf_idle = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_start_address = 32'h1000;
    bus.req_length = 32'd64;
    repeat (3) @(negedge clk);
    #3;
    check("no_accept_ready", 64'(bus.req_ready), 64'd0);
    check("no_accept_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.buf_idle = 1'b1;

    run_fill(32'h0000_1000, 32'd64);
`ifdef PREFETCH_FILL_STATS_EN
    check("stat_cycles", 64'(stat_fill_cycles), 64'd12);
`endif
    run_fill(32'h0000_1004, 32'd8);

    stall_on = 1;
    stall_left = 3;
    run_fill(32'h0000_2000, 32'd300);
    check("stall_cycles", 64'(stall_seen), 64'd3);
    stall_on = -1;

    run_fill(32'h0000_3000, 32'd0);
    check("len0_no_bursts", 64'(req_cnt), 64'd0);
    check("len0_spacing", 64'(fin_cyc), 64'(wait_cyc + 2));

    run_fill(32'h0001_0003, 32'd40000);

    // reset in the middle of a fill with beats still returning
    model(32'h0000_4000, 32'd512, b, ovf, blen, nb);
    issue_req(32'h0000_4000, 32'd512);
    got = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      #3;
      if (wr_cnt >= 10) begin got = 1; break; end
    end
    check("midfill_reached", 64'(got), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    dropping = 1'b1;
    inflight = pend.size();
    check("beats_in_flight", 64'(inflight > 2), 64'd1);
    @(negedge clk);
    #3;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    exp_wr.delete();
    exp_br.delete();
    for (int t = 0; t < 200 && pend.size() > 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    #3;
    check("dropped_writes", 64'(drop_wr), 64'd0);
    check("post_rst_idle", 64'(bus.busy), 64'd0);
    dropping = 1'b0;

    run_fill(32'h0000_5004, 32'd8);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule
